// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers them in a small FIFO and hands {instr, pc, pc+4} to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_pc_plus4
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);
   localparam logic [31:0]    NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   drain_addr;
   logic [31:0]   target_pc;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // A request is only raised with buffer space free, and since only an ack can
   // consume that space, the request stays up until its ack without extra state.
   assign imem_req  = (state == DRAIN) || ((state == FETCH) && (count < FULL));
   assign imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;

   assign push = (state == FETCH) && imem_req && imem_ack && !redirect;
   assign pop  = dec_valid && dec_ready;

   assign dec_valid    = (count != '0);
   assign dec_instr    = dec_valid ? instr_mem[rd_ptr] : NOP;
   assign dec_pc       = dec_valid ? pc_mem[rd_ptr] : 32'h0;
   assign dec_pc_plus4 = dec_pc + 32'd4;

   // Redirect overrides everything; an unanswered request must be drained at
   // its original address before fetching from the new target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         drain_addr <= 32'h0;
      end else if (redirect) begin
         fetch_pc <= target_pc;
         if (imem_req && !imem_ack) begin
            state      <= DRAIN;
            drain_addr <= imem_addr;
         end else begin
            state <= FETCH;
         end
      end else begin
         case (state)
            IDLE:    state <= FETCH;
            FETCH:   if (push) fetch_pc <= fetch_pc + 32'd4;
            DRAIN:   if (imem_ack) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a sequential-PC stream model feeds an expected
// queue, a monitor pops it on every decode handshake and checks the handshakes.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] plus4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_pc_plus4;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [31:0] gen_pc;
   int   lat_mode = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr + 32'h100;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic refill();
      exp_t e;
      while (exp_q.size() < 16) begin
         e.pc    = gen_pc;
         e.instr = memWord(gen_pc);
         e.plus4 = gen_pc + 32'd4;
         exp_q.push_back(e);
         gen_pc  = gen_pc + 32'd4;
      end
   endtask

   task automatic reseed(input logic [31:0] pc);
      exp_q.delete();
      gen_pc = pc;
      refill();
   endtask

   // Drive one cycle's inputs just after the active edge; a redirect restarts
   // the expected instruction stream at the word-aligned target.
   task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] target);
      @(posedge clk);
      #1;
      dec_ready   = rdy;
      redirect    = redir;
      redirect_pc = target;
      if (redir) reseed(target & 32'hFFFF_FFFC);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      redirect = 1'b0;
      reseed(RESET_PC);
      #1;
      checkOutput("rst_req", 32'(imem_req), 32'h0);
      checkOutput("rst_valid", 32'(dec_valid), 32'h0);
      checkOutput("rst_instr", dec_instr, NOP);
      checkOutput("rst_pc", dec_pc, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_req", 32'(imem_req), 32'h0);
   endtask

   // Memory model: latency per request is fixed by lat_mode, or random (0..3)
   // when lat_mode is negative; garbage on rdata whenever ack is low.
   int  mem_cnt = 0;
   int  mem_lat = 0;
   bit  mem_new = 1'b1;
   always begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
         imem_ack = 1'b0;
         mem_cnt  = 0;
         mem_new  = 1'b1;
      end else begin
         if (imem_ack) mem_new = 1'b1;
         imem_ack   = 1'b0;
         imem_rdata = $urandom();
         if (imem_req) begin
            if (mem_new) begin
               mem_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
               mem_cnt = 0;
               mem_new = 1'b0;
            end
            if (mem_cnt >= mem_lat) begin
               imem_ack   = 1'b1;
               imem_rdata = memWord(imem_addr);
            end else begin
               mem_cnt++;
            end
         end
      end
   end

   // Monitor: protocol hold, post-redirect flush and in-order delivery checks.
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_redir = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   int          idle = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_req   = 1'b0;
         prev_redir = 1'b0;
         idle       = 0;
      end else begin
         if (prev_req && !prev_ack) begin
            checkOutput("req_hold", 32'(imem_req), 32'h1);
            checkOutput("addr_hold", imem_addr, prev_addr);
         end
         if (imem_req) checkOutput("addr_align", 32'(imem_addr[1:0]), 32'h0);
         if (prev_redir) checkOutput("flush_valid", 32'(dec_valid), 32'h0);
         if (dec_valid && dec_ready && !redirect) begin
            idle = 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL deliver: got pc %h, expected queue empty", dec_pc);
            end else begin
               e = exp_q.pop_front();
               checkOutput("dec_pc", dec_pc, e.pc);
               checkOutput("dec_instr", dec_instr, e.instr);
               checkOutput("dec_pc_plus4", dec_pc_plus4, e.plus4);
               refill();
            end
         end else if (dec_ready) begin
            idle++;
            if (idle > 60) begin
               checks++;
               errors++;
               $display("[TB] FAIL progress: got %0d idle cycles, expected at most 60", idle);
               idle = 0;
            end
         end
         prev_req   = imem_req;
         prev_ack   = imem_ack;
         prev_addr  = imem_addr;
         prev_redir = redirect;
      end
   end

   initial begin
      bit found;

      // Zero-wait memory streams one instruction per cycle.
      lat_mode  = 0;
      dec_ready = 1'b1;
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         checkOutput("stream_req", 32'(imem_req), 32'h1);
         checkOutput("stream_addr", imem_addr, 32'(i * 4));
      end

      // Backpressure: buffer fills to two entries, then one pop frees a slot.
      dec_ready = 1'b0;
      doReset();
      repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("full_req", 32'(imem_req), 32'h0);
      checkOutput("full_head", dec_pc, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("refill_req", 32'(imem_req), 32'h1);
      checkOutput("refill_addr", imem_addr, 32'h8);

      // Redirect while a slow request is outstanding forces a drain.
      lat_mode  = 3;
      dec_ready = 1'b1;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         if (imem_req && imem_addr == 32'h8) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_req8: got no request at 00000008, expected one within 40 cycles");
      end
      applyStimulus(1'b1, 1'b1, 32'h0000_0200);
      @(negedge clk);
      checkOutput("redir_addr", imem_addr, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("drain_req", 32'(imem_req), 32'h1);
      checkOutput("drain_addr", imem_addr, 32'h8);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         @(negedge clk);
         if (imem_req && imem_addr != 32'h8) begin
            found = 1'b1;
            checkOutput("target_addr", imem_addr, 32'h200);
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_target: got no new request, expected 00000200 within 20 cycles");
      end
      repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);

      // Redirect coinciding with an ack and a pop, unaligned target.
      lat_mode = 0;
      doReset();
      repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0043);
      @(negedge clk);
      checkOutput("coinc_ack", 32'(imem_ack), 32'h1);
      checkOutput("coinc_valid", 32'(dec_valid), 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("coinc_flush", 32'(dec_valid), 32'h0);
      checkOutput("coinc_addr", imem_addr, 32'h40);

      // PC wrap at the top of the address space.
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("wrap_addr1", imem_addr, 32'h0);
      checkOutput("wrap_pc", dec_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_plus4", dec_pc_plus4, 32'h0);

      // Asynchronous reset in the middle of a pending request.
      dec_ready = 1'b0;
      doReset();
      repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
      lat_mode = 3;
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("pend_req", 32'(imem_req), 32'h1);
      checkOutput("pend_valid", 32'(dec_valid), 32'h1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      reseed(RESET_PC);
      #1;
      checkOutput("async_req", 32'(imem_req), 32'h0);
      checkOutput("async_valid", 32'(dec_valid), 32'h0);
      checkOutput("async_instr", dec_instr, NOP);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("async_idle", 32'(imem_req), 32'h0);
      @(negedge clk);
      checkOutput("async_first_req", 32'(imem_req), 32'h1);
      checkOutput("async_first_addr", imem_addr, RESET_PC);

      // Randomised traffic: variable latency, backpressure and redirects.
      lat_mode = -1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0)
            applyStimulus($urandom_range(0, 9) < 7, 1'b1,
                          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                      : $urandom());
         else
            applyStimulus($urandom_range(0, 9) < 7, 1'b0, 32'h0);
      end
      repeat (10) applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
